dmem_responder: RTL and testbench

- Memory-side responder for the ARM core's data port.
- Accepts word read/write requests over a valid/ready handshake, inserts a fixed number of wait states, then returns a one-cycle response carrying read data and an error flag.
- Sits between the processor's load/store path and on-chip data RAM.
- Models realistic memory latency so the core's stall logic can be exercised.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  localparam int WORD_W = 32;

  // Output-register address used when the top is not given one explicitly.
  localparam logic [31:0] DEFAULT_OUT_ADDR = 32'h0000_0400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  // Registered response payload; all-zero whenever no response is presented.
  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } rsp_t;

  // Word-index width for a RAM of the given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, synchronous write, combinational read
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port: contents are never cleared, only overwritten.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder; DMEM_OUTPORT_EN adds a memory-mapped output register
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] OUT_ADDR    = DEFAULT_OUT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_OUTPORT_EN
  ,
  output logic [31:0] out_data
`endif
);

  localparam int AW = idx_width(DEPTH);
  // Counter only ever holds WAIT_STATES-1 down to 0.
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

`ifdef DMEM_OUTPORT_EN
  localparam bit OUT_EN = 1'b1;
`else
  localparam bit OUT_EN = 1'b0;
`endif

  // Range bounds carried in 34 bits so BASE_ADDR near the top of the map cannot wrap.
  localparam logic [33:0] RAM_LO = {2'b00, BASE_ADDR};
  localparam logic [33:0] RAM_HI = RAM_LO + 34'(4 * DEPTH);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              write_q;
  logic [31:0]       addr_q, wdata_q;
  logic              accept;

  logic              sel_write;
  logic [31:0]       sel_addr, sel_wdata;
  logic              aligned, in_range, ram_hit, out_match, out_hit;
  logic [33:0]       addr_x;
  logic [31:0]       word_off;
  logic [AW-1:0]     ram_idx;
  logic              unused_off;
  logic [WORD_W-1:0] ram_rdata, out_val;
  logic              enter_resp, ram_we;
  rsp_t              rsp_d, rsp_q;

  // Next-state logic: accept in idle, count down wait states, present one response cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and wait counter; reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold the accepted request so the requester may move on after the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // With zero wait states the response edge is the acceptance edge, so decode
  // must see the live request in idle and the captured one afterwards.
  assign sel_write = (state_q == S_IDLE) ? req_write : write_q;
  assign sel_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign sel_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  assign addr_x    = {2'b00, sel_addr};
  assign aligned   = (sel_addr[1:0] == 2'b00);
  assign in_range  = (addr_x >= RAM_LO) && (addr_x < RAM_HI);
  assign ram_hit   = aligned && in_range;
  assign out_match = (sel_addr == OUT_ADDR);
  assign out_hit   = OUT_EN && out_match && !ram_hit;

  assign word_off   = sel_addr - BASE_ADDR;
  assign ram_idx    = word_off[AW+1:2];
  assign unused_off = ^{word_off[31:AW+2], word_off[1:0]};

  // The only edge that leads into S_RESP is the one that commits the access.
  assign enter_resp = (state_d == S_RESP);
  assign ram_we     = enter_resp && sel_write && ram_hit && !reset;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_idx),
    .wdata_i (sel_wdata),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_OUTPORT_EN
  logic [WORD_W-1:0] out_q;

  // Output register shares the commit edge with RAM writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (enter_resp && sel_write && out_hit) begin
      out_q <= sel_wdata;
    end
  end

  assign out_val  = out_q;
  assign out_data = out_q;
`else
  assign out_val = '0;
`endif

  // Response payload: errors and writes return zero data.
  always_comb begin
    rsp_d = '0;
    if (!(ram_hit || out_hit)) begin
      rsp_d.err = 1'b1;
    end else if (!sel_write) begin
      rsp_d.rdata = ram_hit ? ram_rdata : out_val;
    end
  end

  // Response register is loaded for the S_RESP cycle only and zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q <= '0;
    end else if (enter_resp) begin
      rsp_q <= rsp_d;
    end else begin
      rsp_q <= '0;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at two wait-state settings; honours DMEM_OUTPORT_EN
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam int          WS0   = 2;
  localparam int          WS1   = 0;
  localparam logic [31:0] OUT_A = 32'h0000_0400;
  localparam int          LIMIT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
`ifdef DMEM_OUTPORT_EN
  logic [31:0] out_data  [2];
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] out_m [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_write (req_write[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
`ifdef DMEM_OUTPORT_EN
    ,
    .out_data  (out_data[0])
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_write (req_write[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
`ifdef DMEM_OUTPORT_EN
    ,
    .out_data  (out_data[1])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Reference behaviour: aligned word inside [0, 4*DEPTH) hits the RAM.
  task automatic predict(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d, output exp_t e);
    bit hit;
    hit     = (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    e.err   = 1'b1;
    e.rdata = '0;
    e.cyc   = 0;
    if (hit) begin
      e.err = 1'b0;
      if (w) mem_m[k][a[7:2]] = d;
      else   e.rdata = mem_m[k][a[7:2]];
    end
`ifdef DMEM_OUTPORT_EN
    else if (a == OUT_A) begin
      e.err = 1'b0;
      if (w) out_m[k] = d;
      else   e.rdata = out_m[k];
    end
`endif
  endtask

  // Present a request (called just after a falling edge), wait for acceptance,
  // log the expected response and its cycle, return on the next falling edge.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int c0);
    int   n;
    exp_t e;
    n = 0;
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    while (!req_ready[k] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("accept_wait%0d", k), 32'(n < LIMIT), 32'd1);
    c0 = cyc;
    predict(k, w, a, d, e);
    e.cyc = c0 + 1 + ws_of(k);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    if (!hold) req_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("drain%0d", k), 32'(n < LIMIT), 32'd1);
    @(negedge clk);
  endtask

  // Response monitor: every response must match the oldest expectation and its cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid[k]) begin
        if (qsize(k) == 0) begin
          check_eq($sformatf("unexpected_rsp%0d", k), 32'(rsp_valid[k]), 32'd0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check_eq($sformatf("rsp_rdata%0d", k), rsp_rdata[k], e.rdata);
          check_eq($sformatf("rsp_err%0d", k), 32'(rsp_err[k]), 32'(e.err));
          check_eq($sformatf("rsp_cycle%0d", k), 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check_eq($sformatf("idle_rdata%0d", k), rsp_rdata[k], 32'd0);
        check_eq($sformatf("idle_err%0d", k), 32'(rsp_err[k]), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca;
    int cb;
    int c;
    logic [31:0] a;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      out_m[k]     = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("reset_ready%0d", k), 32'(req_ready[k]), 32'd1);
      check_eq($sformatf("reset_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
      check_eq($sformatf("reset_rdata%0d", k), rsp_rdata[k], 32'd0);
      check_eq($sformatf("reset_err%0d", k), 32'(rsp_err[k]), 32'd0);
`ifdef DMEM_OUTPORT_EN
      check_eq($sformatf("reset_out%0d", k), out_data[k], 32'd0);
`endif
    end

    // Fill both RAMs so every later read has a known value.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) issue(k, 1'b1, 32'(i * 4), $urandom, 1'b0, c);
      drain(k);
    end
    for (int i = 0; i < DEPTH; i++) issue(1, 1'b0, 32'(i * 4), '0, 1'b0, c);
    drain(1);

    // Two wait states: write then read, errors, last word.
    issue(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, c);
    issue(0, 1'b0, 32'h08, '0, 1'b0, c);
    issue(0, 1'b0, 32'h100, '0, 1'b0, c);
    issue(0, 1'b0, 32'h06, '0, 1'b0, c);
    issue(0, 1'b1, 32'hFC, 32'h1234, 1'b0, c);
    issue(0, 1'b0, 32'hFC, '0, 1'b0, c);
    issue(0, 1'b0, 32'hFFFF_FFFC, '0, 1'b0, c);
    issue(0, 1'b1, 32'hFFFF_FF00, 32'h55, 1'b0, c);
    issue(0, 1'b1, OUT_A, 32'hA5, 1'b0, c);
    drain(0);
`ifdef DMEM_OUTPORT_EN
    check_eq("out_data0", out_data[0], 32'hA5);
`endif
    issue(0, 1'b0, OUT_A, '0, 1'b0, c);
    drain(0);

    // Held request valid: next acceptance WAIT_STATES+2 cycles later.
    issue(0, 1'b1, 32'h20, 32'h1111, 1'b1, ca);
    issue(0, 1'b1, 32'h24, 32'h2222, 1'b0, cb);
    check_eq("thru_ws2", 32'(cb - ca), 32'(WS0 + 2));
    drain(0);

    // Zero wait states: back-to-back writes with req_valid held.
    issue(1, 1'b1, 32'h0, 32'h1, 1'b1, ca);
    check_eq("ready_cycle1", 32'(req_ready[1]), 32'd0);
    issue(1, 1'b1, 32'h4, 32'h2, 1'b0, cb);
    check_eq("ready_cycle3", 32'(req_ready[1]), 32'd0);
    check_eq("thru_ws0", 32'(cb - ca), 32'd2);
    issue(1, 1'b0, 32'h0, '0, 1'b0, c);
    issue(1, 1'b0, 32'h4, '0, 1'b0, c);
    issue(1, 1'b1, OUT_A, 32'h5A, 1'b0, c);
    drain(1);
`ifdef DMEM_OUTPORT_EN
    check_eq("out_data1", out_data[1], 32'h5A);
`endif

    // Mixed random traffic, including some misaligned and out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, DEPTH + 3) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'd2;
      issue(i % 2, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, c);
      drain(i % 2);
    end

    // Reset during the first wait cycle of a write aborts it silently.
    issue(0, 1'b1, 32'h10, 32'h5, 1'b0, c);
    drain(0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h77;
    @(negedge clk);
    reset        = 1'b1;
    req_valid[0] = 1'b0;
    #1;
    check_eq("abort_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    issue(0, 1'b0, 32'h10, '0, 1'b0, c);
    drain(0);

    repeat (3) @(negedge clk);
    check_eq("queues_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
